// File: rtl/uart_rx_ctrl.sv
// Receive-side sequencer for the UART bit receiver: generates the rxck bit clock,
// commits each completed frame's byte to a small FIFO and serves host pops.
module uart_rx_ctrl #(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int AW         = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx_enable,
    output logic          rxck,
    input  logic [7:0]    rxpd,
    input  logic          rxen,
    input  logic          rx_start,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
    output logic          fifo_empty,
    output logic          fifo_full,
    output logic [AW:0]   fifo_level,
    output logic          overrun,
    input  logic          clr_err,
    output logic          busy,
    output logic [1:0]    dbg_state
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
    localparam logic [AW:0]   DEPTH    = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PUSH = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t          state_q;
    logic [DW-1:0]   div_cnt_q;
    logic            rxck_q;
    logic            rxen_q;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     level_q, level_d;
    logic [7:0]      rd_data_q;
    logic            rd_valid_q;
    logic            overrun_q, overrun_d;

    logic rise, empty, full, pop, push, drop;

    // Handshakes: a pop happens on any cycle with rd_en=1 and the FIFO non-empty; rd_data/rd_valid
    // follow one cycle later. A push happens in the single PUSH cycle when there is room, counting
    // a same-cycle pop as freeing a slot.
    assign rise  = rxen & ~rxen_q;
    assign empty = (level_q == '0);
    assign full  = (level_q == DEPTH);
    assign pop   = rd_en & ~empty;
    assign push  = (state_q == S_PUSH) & (~full | pop);
    assign drop  = (state_q == S_PUSH) & ~push;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt_q <= '0;
            rxck_q    <= 1'b0;
        end else if (!rx_enable) begin
            div_cnt_q <= '0;
            rxck_q    <= 1'b0;
        end else begin
            rxck_q    <= (div_cnt_q < DIV_HALF);
            div_cnt_q <= (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxen_q  <= 1'b0;
            state_q <= S_IDLE;
        end else begin
            rxen_q <= rxen;
            if (!rx_enable) begin
                state_q <= S_IDLE;
            end else begin
                unique case (state_q)
                    S_IDLE:  if (rise) state_q <= S_PUSH;
                    S_PUSH:  state_q <= S_HOLD;
                    S_HOLD:  if (!rxen) state_q <= S_IDLE;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d   = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + (AW + 1)'(1);
            2'b01:   level_d = level_q - (AW + 1)'(1);
            default: level_d = level_q;
        endcase
        // A drop in the same cycle as clr_err must leave the error visible.
        overrun_d = drop ? 1'b1 : (clr_err ? 1'b0 : overrun_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            rd_valid_q <= pop;
            overrun_q  <= overrun_d;
            if (pop) rd_data_q <= mem_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= rxpd;
    end

    assign rxck       = rxck_q;
    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign fifo_empty = empty;
    assign fifo_full  = full;
    assign fifo_level = level_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != S_IDLE) | rx_start;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: bit clock shape, frame capture latency, FIFO
// full/overrun behaviour, push/pop collision at full, and mid-frame reset.
module tb_uart_rx_ctrl;
    localparam int CLK_DIV = 16;
    localparam int DEPTH   = 8;
    localparam int AW      = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rx_enable = 1'b0;
    logic          rxck;
    logic [7:0]    rxpd = 8'h00;
    logic          rxen = 1'b0;
    logic          rx_start = 1'b0;
    logic          rd_en = 1'b0;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic          fifo_empty;
    logic          fifo_full;
    logic [AW:0]   fifo_level;
    logic          overrun;
    logic          clr_err = 1'b0;
    logic          busy;
    logic [1:0]    dbg_state;

    int checks = 0;
    int passed = 0;
    int highs;

    uart_rx_ctrl #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .rx_enable(rx_enable), .rxck(rxck), .rxpd(rxpd),
        .rxen(rxen), .rx_start(rx_start), .rd_en(rd_en), .rd_data(rd_data),
        .rd_valid(rd_valid), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
        .fifo_level(fifo_level), .overrun(overrun), .clr_err(clr_err),
        .busy(busy), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // rxen high for 3 cycles covers PUSH and HOLD; 2 idle cycles let rxen_q settle low.
    task automatic send_frame(input logic [7:0] b);
        rxpd = b;
        rxen = 1'b1;
        tick(3);
        rxen = 1'b0;
        tick(2);
    endtask

    initial begin
        #1;
        check("rst_rxck", rxck, 0);
        check("rst_level", fifo_level, 0);
        check("rst_empty", fifo_empty, 1);
        check("rst_full", fifo_full, 0);
        check("rst_rd_data", rd_data, 8'h00);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        check("rst_state", dbg_state, 0);
        tick(2);
        rst = 1'b1;
        tick(1);

        // bit clock: 8 high then 8 low, period 16
        rx_enable = 1'b1;
        highs = 0;
        for (int i = 1; i <= 16; i++) begin
            tick(1);
            if (i == 1) check("rxck_first_high", rxck, 1);
            if (i == 9) check("rxck_first_low", rxck, 0);
            if (rxck) highs++;
        end
        check("rxck_high_count", highs, 8);
        tick(1);
        check("rxck_period", rxck, 1);
        rx_enable = 1'b0;
        tick(1);
        check("rxck_disable", rxck, 0);
        rx_enable = 1'b1;
        tick(3);

        // single frame, latency and read
        rxpd = 8'hA5;
        rxen = 1'b1;
        tick(1);
        check("lat_level_n1", fifo_level, 0);
        check("lat_state_push", dbg_state, 1);
        check("lat_busy", busy, 1);
        tick(1);
        check("lat_level_n2", fifo_level, 1);
        check("lat_state_hold", dbg_state, 2);
        tick(158);
        rxen = 1'b0;
        tick(1);
        check("hold_to_idle", dbg_state, 0);
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        check("rd1_valid", rd_valid, 1);
        check("rd1_data", rd_data, 8'hA5);
        check("rd1_empty", fifo_empty, 1);
        tick(1);
        check("rd1_valid_pulse", rd_valid, 0);

        // fill, overflow, drain in order
        for (int i = 0; i < 8; i++) send_frame(8'(i));
        check("fill_full", fifo_full, 1);
        check("fill_level", fifo_level, 8);
        check("fill_no_overrun", overrun, 0);
        send_frame(8'hFF);
        check("ovf_overrun", overrun, 1);
        check("ovf_level", fifo_level, 8);
        rd_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            check("drain_valid", rd_valid, 1);
            check("drain_data", rd_data, i);
        end
        rd_en = 1'b0;
        tick(1);
        check("drain_empty", fifo_empty, 1);
        check("drain_valid_end", rd_valid, 0);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        check("clr_after_drain", overrun, 0);

        // push at full with same-cycle pop
        for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i));
        rxpd = 8'h3C;
        rxen = 1'b1;
        tick(1);
        check("coll_state_push", dbg_state, 1);
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        check("coll_rd_data", rd_data, 8'h10);
        check("coll_level", fifo_level, 8);
        check("coll_overrun", overrun, 0);
        rxen = 1'b0;
        tick(2);
        rd_en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick(1);
            check("coll_drain", rd_data, 8'h11 + 8'(i));
        end
        tick(1);
        check("coll_last", rd_data, 8'h3C);
        rd_en = 1'b0;
        tick(1);
        check("coll_empty", fifo_empty, 1);

        // overrun set beats clr_err
        for (int i = 0; i < 8; i++) send_frame(8'h20 + 8'(i));
        send_frame(8'hFF);
        check("ovr2_set", overrun, 1);
        rxpd = 8'hEE;
        rxen = 1'b1;
        tick(1);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        check("ovr_set_wins", overrun, 1);
        rxen = 1'b0;
        tick(2);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        check("ovr_clr_alone", overrun, 0);
        check("ovr_level", fifo_level, 8);

        // reset during HOLD with three entries
        rd_en = 1'b1;
        tick(6);
        rd_en = 1'b0;
        tick(1);
        check("pre_rst_level", fifo_level, 2);
        rxpd = 8'h55;
        rxen = 1'b1;
        tick(2);
        check("pre_rst_hold", dbg_state, 2);
        check("pre_rst_level3", fifo_level, 3);
        rst = 1'b0;
        #1;
        check("mid_rst_level", fifo_level, 0);
        check("mid_rst_empty", fifo_empty, 1);
        check("mid_rst_state", dbg_state, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_rxck", rxck, 0);
        rxen = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(1);
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        check("empty_rd_valid", rd_valid, 0);
        check("empty_rd_level", fifo_level, 0);
        rx_start = 1'b1;
        #1;
        check("busy_rx_start", busy, 1);
        rx_start = 1'b0;
        tick(1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
